// File: rtl/rsign_binarize_grouped_pkg.sv
// rsign_pkg: shared mode constants and FSM state type for the RSign binarisation stage.
package rsign_pkg;
    localparam logic MODE_RELOAD    = 1'b0;
    localparam logic MODE_CALCULATE = 1'b1;
    typedef enum logic {IDLE, EMIT} rsign_state_t;
endpackage

// File: rtl/rsign_binarize_grouped_thresh_bank.sv
// rsign_thresh_bank: per-channel threshold registers loaded serially, with load_done pulse.
module rsign_thresh_bank
    import rsign_pkg::*;
#(
    parameter int FM_DEPTH   = 256,
    parameter int PARA_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mode_i,
    input  logic                                 idle_i,
    input  logic                                 para_valid_i,
    input  logic [PARA_WIDTH-1:0]                para_data_i,
    output logic                                 para_ready_o,
    output logic                                 load_done_o,
    output logic [FM_DEPTH-1:0][PARA_WIDTH-1:0]  thr_o
);
    localparam int CW = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;

    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0] thr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q;
    logic          fire, last;

    assign para_ready_o = idle_i & (mode_i == MODE_RELOAD);
    assign fire         = para_valid_i & para_ready_o;
    assign last         = cnt_q == CW'(FM_DEPTH - 1);
    assign load_done_o  = done_q;
    assign thr_o        = thr_q;

    // Leaving RELOAD abandons a partial load; written thresholds stay.
    always_comb cnt_d = fire ? (last ? '0 : cnt_q + CW'(1)) : (mode_i == MODE_CALCULATE ? '0 : cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= fire & last;
            if (fire) thr_q[cnt_q] <= para_data_i;
        end
    end
endmodule

// File: rtl/rsign_binarize_grouped.sv
// rsign_binarize_grouped: binarise a FM_DEPTH x WIN window against per-channel thresholds
// and stream it out as NUM_GROUPS channel slices under valid/ready.
module rsign_binarize_grouped
    import rsign_pkg::*;
#(
    parameter int FM_DEPTH   = 256,
    parameter int NUM_GROUPS = 2,
    parameter int WIN        = 9,
    parameter int DATA_WIDTH = 8,
    parameter int PARA_WIDTH = 8,
    localparam int GRP_CH    = FM_DEPTH / NUM_GROUPS,
    localparam int GW        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mode_i,
    input  logic                               para_valid_i,
    output logic                               para_ready_o,
    input  logic [PARA_WIDTH-1:0]              para_data_i,
    output logic                               load_done_o,
    input  logic                               data_e_i,
    output logic                               in_ready_o,
    input  logic [FM_DEPTH*WIN*DATA_WIDTH-1:0] data_in_i,
    output logic [GRP_CH*WIN-1:0]              data_out_o,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [GW-1:0]                      out_grp_o
);
    localparam int SW = GRP_CH * WIN;

    rsign_state_t                        state_q, state_d;
    logic [FM_DEPTH*WIN-1:0]             bin_q, bin_d, cmp;
    logic [SW-1:0]                       dout_q, dout_d;
    logic [GW-1:0]                       grp_q, grp_d, nxt;
    logic                                valid_q, valid_d;
    logic [FM_DEPTH-1:0][PARA_WIDTH-1:0] thr;
    logic                                idle, take, fire, last;

    rsign_thresh_bank #(.FM_DEPTH(FM_DEPTH), .PARA_WIDTH(PARA_WIDTH)) u_bank (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .idle_i       (idle),
        .para_valid_i (para_valid_i),
        .para_data_i  (para_data_i),
        .para_ready_o (para_ready_o),
        .load_done_o  (load_done_o),
        .thr_o        (thr)
    );

    always_comb begin
        cmp = '0;
        for (int c = 0; c < FM_DEPTH; c++)
            for (int k = 0; k < WIN; k++)
                cmp[c*WIN+k] = $signed(data_in_i[(c*WIN+k)*DATA_WIDTH +: DATA_WIDTH]) > $signed(thr[c]);
    end

    assign idle        = state_q == IDLE;
    assign in_ready_o  = idle & (mode_i == MODE_CALCULATE);
    assign take        = data_e_i & in_ready_o;
    assign fire        = valid_q & out_ready_i;
    assign last        = grp_q == GW'(NUM_GROUPS - 1);
    assign nxt         = grp_q + GW'(1);
    assign data_out_o  = dout_q;
    assign out_valid_o = valid_q;
    assign out_grp_o   = grp_q;

    // Slice 0 is loaded straight from the compare so it is valid the cycle after capture.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        dout_d  = dout_q;
        grp_d   = grp_q;
        valid_d = valid_q;
        if (take) begin
            state_d = EMIT;
            bin_d   = cmp;
            dout_d  = cmp[SW-1:0];
            valid_d = 1'b1;
        end else if (fire) begin
            state_d = last ? IDLE : EMIT;
            valid_d = ~last;
            grp_d   = last ? '0 : nxt;
            dout_d  = last ? dout_q : bin_q[nxt*SW +: SW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dout_q  <= '0;
            grp_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dout_q  <= dout_d;
            grp_q   <= grp_d;
            valid_q <= valid_d;
        end
    end
endmodule
